cache_replacement_unit: RTL and testbench

- Per-set way-allocation state for the set-associative data cache.
- Sits beside the cache controller and feeds its `populate_way`, `populated` and `replace_way` inputs.
- Consumes the controller's `set`, `write_way` and `cru_enable`, plus hit information from the tag-compare stage.
- Holds per-set valid bits and tree pseudo-LRU bits. Answers combinationally for the presented set and updates state on the clock edge.

---
 rtl/cache_pkg.sv | 33 +++
 rtl/cache_replacement_unit_if.sv | 29 ++
 rtl/plru_tree.sv | 40 ++++
 rtl/cache_replacement_unit.sv | 58 +++++
 tb/tb_cache_replacement_unit.sv | 197 +++++++++++++++++++
 5 files changed

// File: rtl/cache_pkg.sv
// cache_pkg: definitions shared by the cache controller and the replacement unit.
package cache_pkg;

    localparam int NumSets = 16;
    localparam int NumWays = 4;
    localparam int AddrWidth = 32;
    localparam int OffsetSize = 4;

    function automatic int set_size(input int num_sets);
        return $clog2(num_sets);
    endfunction

    function automatic int way_size(input int num_ways);
        return $clog2(num_ways);
    endfunction

    localparam int SetSize = $clog2(NumSets);
    localparam int WaySize = $clog2(NumWays);
    localparam int TagSize = AddrWidth - SetSize - OffsetSize;

    typedef struct packed {
        logic [TagSize-1:0]    tag;
        logic [SetSize-1:0]    set;
        logic [OffsetSize-1:0] offset;
    } cache_addr_t;

    typedef enum logic [1:0] {
        READ,
        WRITE_POPULATE,
        WRITE_REPLACE
    } ctrl_state_t;

endpackage

// File: rtl/cache_replacement_unit_if.sv
// cache_replacement_unit_if: controller <-> replacement unit signals.
interface cache_replacement_unit_if
    import cache_pkg::*;
#(
    parameter int NUM_SETS = NumSets,
    parameter int NUM_WAYS = NumWays
) ();
    logic [set_size(NUM_SETS)-1:0] set;
    logic                          hit;
    logic [way_size(NUM_WAYS)-1:0] hit_way;
    logic                          fill_enable;
    logic [way_size(NUM_WAYS)-1:0] write_way;
    logic                          cru_enable;
    logic                          flush;
    logic                          populated;
    logic [way_size(NUM_WAYS)-1:0] populate_way;
    logic [way_size(NUM_WAYS)-1:0] replace_way;
    logic [15:0]                   replace_count;

    modport master (
        output set, hit, hit_way, fill_enable, write_way, cru_enable, flush,
        input  populated, populate_way, replace_way, replace_count
    );

    modport slave (
        input  set, hit, hit_way, fill_enable, write_way, cru_enable, flush,
        output populated, populate_way, replace_way, replace_count
    );
endinterface

// File: rtl/plru_tree.sv
// plru_tree: tree pseudo-LRU victim selection and touch update for one set.
module plru_tree
    import cache_pkg::*;
#(
    parameter int NUM_WAYS = NumWays
) (
    input  logic [NUM_WAYS-2:0]            tree,
    input  logic [way_size(NUM_WAYS)-1:0]  touch_way,
    output logic [way_size(NUM_WAYS)-1:0]  victim,
    output logic [NUM_WAYS-2:0]            next_tree
);
    localparam int Levels = way_size(NUM_WAYS);

    // The victim's index bits are exactly the tree bits met on the walk, MSB first.
    always_comb begin
        logic [Levels-1:0] node;
        victim = '0;
        node   = '0;
        for (int l = 0; l < Levels; l++) begin
            victim = {victim[Levels-2:0], tree[node]};
            node   = (node << 1) + Levels'(1) + Levels'(tree[node]);
        end
    end

    // Each node on the touched path points to the sibling subtree.
    always_comb begin
        logic [Levels-1:0] node;
        logic [Levels-1:0] tw;
        logic              dir;
        next_tree = tree;
        node      = '0;
        tw        = touch_way;
        for (int l = 0; l < Levels; l++) begin
            dir             = tw[Levels-1];
            next_tree[node] = ~dir;
            node            = (node << 1) + Levels'(1) + Levels'(dir);
            tw              = tw << 1;
        end
    end
endmodule

// File: rtl/cache_replacement_unit.sv
// cache_replacement_unit: per-set valid/PLRU state feeding the cache controller's
// populate and replace decisions, plus a saturating replacement counter.
module cache_replacement_unit
    import cache_pkg::*;
#(
    parameter int NUM_SETS = NumSets,
    parameter int NUM_WAYS = NumWays
) (
    input logic                    clk,
    input logic                    rstn,
    cache_replacement_unit_if.slave bus
);
    localparam int WayBits = way_size(NUM_WAYS);

    logic [NUM_WAYS-1:0] valid_q [NUM_SETS];
    logic [NUM_WAYS-2:0] plru_q  [NUM_SETS];
    logic [NUM_WAYS-2:0] plru_next;
    logic [15:0]         cnt_q;
    logic                touch;
    logic [WayBits-1:0]  touch_way;

    assign touch     = bus.fill_enable | bus.hit;
    assign touch_way = bus.fill_enable ? bus.write_way : bus.hit_way;

    plru_tree #(.NUM_WAYS(NUM_WAYS)) u_plru (
        .tree      (plru_q[bus.set]),
        .touch_way (touch_way),
        .victim    (bus.replace_way),
        .next_tree (plru_next)
    );

    assign bus.populated     = &valid_q[bus.set];
    assign bus.replace_count = cnt_q;

    always_comb begin
        bus.populate_way = '0;
        for (int i = NUM_WAYS - 1; i >= 0; i--)
            if (!valid_q[bus.set][i]) bus.populate_way = WayBits'(i);
    end

    // Flush discards any touch or fill presented in the same cycle.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn || bus.flush) begin
            for (int i = 0; i < NUM_SETS; i++) begin
                valid_q[i] <= '0;
                plru_q[i]  <= '0;
            end
        end else begin
            if (touch) plru_q[bus.set] <= plru_next;
            if (bus.fill_enable) valid_q[bus.set][bus.write_way] <= 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) cnt_q <= '0;
        else if (bus.fill_enable && bus.cru_enable && !bus.flush && !(&cnt_q)) cnt_q <= cnt_q + 16'd1;
    end
endmodule

// File: tb/tb_cache_replacement_unit.sv
// tb_cache_replacement_unit: directed and random checks against a behavioural model.
module tb_cache_replacement_unit;
    logic clk = 1'b0;
    logic rstn = 1'b0;
    int n_checks = 0;
    int n_pass = 0;

    bit [3:0] mv [16];
    bit [2:0] mt [16];
    int       mcnt;

    cache_replacement_unit_if #(.NUM_SETS(16), .NUM_WAYS(4)) bus ();

    cache_replacement_unit #(.NUM_SETS(16), .NUM_WAYS(4)) dut (
        .clk  (clk),
        .rstn (rstn),
        .bus  (bus)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    endtask

    task automatic m_reset(input bit keep_cnt);
        for (int s = 0; s < 16; s++) begin
            mv[s] = '0;
            mt[s] = '0;
        end
        if (!keep_cnt) mcnt = 0;
    endtask

    // Walk the tree as halving ranges of ways: a set bit sends the walk right.
    function automatic int m_victim(input int s);
        int node = 0, lo = 0, n = 4;
        while (n > 1) begin
            n /= 2;
            if (mt[s][node]) begin
                lo += n;
                node = 2 * node + 2;
            end else node = 2 * node + 1;
        end
        return lo;
    endfunction

    task automatic m_touch(input int s, input int w);
        int node = 0, lo = 0, n = 4;
        while (n > 1) begin
            n /= 2;
            if (w < lo + n) begin
                mt[s][node] = 1'b1;
                node = 2 * node + 1;
            end else begin
                mt[s][node] = 1'b0;
                lo += n;
                node = 2 * node + 2;
            end
        end
    endtask

    function automatic int m_free(input int s);
        for (int w = 0; w < 4; w++) if (!mv[s][w]) return w;
        return 0;
    endfunction

    task automatic m_edge();
        int s = int'(bus.set);
        if (bus.flush) m_reset(1'b1);
        else begin
            if (bus.fill_enable) m_touch(s, int'(bus.write_way));
            else if (bus.hit) m_touch(s, int'(bus.hit_way));
            if (bus.fill_enable) mv[s][bus.write_way] = 1'b1;
            if (bus.fill_enable && bus.cru_enable && mcnt < 65535) mcnt++;
        end
    endtask

    task automatic tick();
        @(posedge clk);
        m_edge();
        #1;
    endtask

    task automatic check_model(input string tag);
        int s = int'(bus.set);
        check({tag, "_populated"}, 32'(bus.populated), 32'(mv[s] == 4'hF));
        check({tag, "_populate_way"}, 32'(bus.populate_way), 32'(m_free(s)));
        check({tag, "_replace_way"}, 32'(bus.replace_way), 32'(m_victim(s)));
        check({tag, "_count"}, 32'(bus.replace_count), 32'(mcnt));
    endtask

    task automatic idle();
        bus.hit = 0; bus.hit_way = 0; bus.fill_enable = 0;
        bus.write_way = 0; bus.cru_enable = 0; bus.flush = 0;
    endtask

    initial begin
        idle();
        bus.set = 4'd3;
        m_reset(1'b0);
        #22 rstn = 1'b1;
        #1;
        check("rst_populated", 32'(bus.populated), 0);
        check("rst_populate_way", 32'(bus.populate_way), 0);
        check("rst_replace_way", 32'(bus.replace_way), 0);
        check("rst_count", 32'(bus.replace_count), 0);
        @(negedge clk);

        for (int w = 0; w < 4; w++) begin
            bus.fill_enable = 1; bus.write_way = 2'(w);
            tick();
            check("fill_populate_way", 32'(bus.populate_way), 32'((w + 1) % 4));
            check("fill_populated", 32'(bus.populated), 32'(w == 3));
        end
        idle();
        #1 check("full_replace_way", 32'(bus.replace_way), 0);

        bus.hit = 1; bus.hit_way = 0; tick();
        check("hit0_replace_way", 32'(bus.replace_way), 2);
        bus.hit_way = 2; tick();
        check("hit2_replace_way", 32'(bus.replace_way), 1);
        bus.hit_way = 1; tick();
        check("hit1_replace_way", 32'(bus.replace_way), 3);
        idle();

        bus.set = 4'd5; bus.fill_enable = 1; bus.write_way = 0; tick();
        idle();
        bus.set = 4'd6;
        #1;
        check("iso_populated", 32'(bus.populated), 0);
        check("iso_populate_way", 32'(bus.populate_way), 0);
        check("iso_replace_way", 32'(bus.replace_way), 0);

        bus.set = 4'd7; bus.hit = 1; bus.hit_way = 3; bus.fill_enable = 1; bus.write_way = 1;
        tick();
        idle();
        #1;
        check("prio_populated", 32'(bus.populated), 0);
        check("prio_populate_way", 32'(bus.populate_way), 0);
        check("prio_replace_way", 32'(bus.replace_way), 2);
        check_model("prio");

        bus.set = 4'd8; bus.fill_enable = 1; bus.cru_enable = 1;
        for (int w = 0; w < 3; w++) begin
            bus.write_way = 2'(w);
            tick();
        end
        check("cnt_three", 32'(bus.replace_count), 3);
        force dut.cnt_q = 16'hFFFE;
        #1 release dut.cnt_q;
        mcnt = 16'hFFFE;
        for (int k = 0; k < 3; k++) tick();
        check("cnt_saturate", 32'(bus.replace_count), 32'hFFFF);
        check_model("cnt");
        idle();

        bus.set = 4'd3; bus.fill_enable = 1; bus.write_way = 2; bus.flush = 1;
        tick();
        idle();
        for (int s = 0; s < 16; s++) begin
            bus.set = 4'(s);
            #1;
            check("flush_populated", 32'(bus.populated), 0);
            check("flush_replace_way", 32'(bus.replace_way), 0);
        end
        check("flush_count", 32'(bus.replace_count), 32'hFFFF);

        for (int i = 0; i < 500; i++) begin
            bus.set = 4'($urandom_range(0, 15));
            bus.hit = 1'($urandom_range(0, 1));
            bus.hit_way = 2'($urandom_range(0, 3));
            bus.fill_enable = ($urandom_range(0, 2) == 0);
            bus.write_way = 2'($urandom_range(0, 3));
            bus.flush = ($urandom_range(0, 39) == 0);
            bus.cru_enable = bus.flush ? 1'b0 : 1'($urandom_range(0, 1));
            #1 check_model("rnd_pre");
            tick();
            check_model("rnd_post");
            if (i == 250) begin
                rstn = 1'b0;
                #1;
                check("async_populated", 32'(bus.populated), 0);
                check("async_populate_way", 32'(bus.populate_way), 0);
                check("async_replace_way", 32'(bus.replace_way), 0);
                check("async_count", 32'(bus.replace_count), 0);
                m_reset(1'b0);
                rstn = 1'b1;
                #1;
            end
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
